// File: rtl/p4_adder_arbiter.sv
// Round-robin arbiter sharing one combinational P4 adder among NREQ requesters; optional subtract via P4_ARB_SUB_EN.
// Latency 2 cycles accept->rsp_valid; rsp_ready low holds RESP and blocks new grants.
package p4_adder_pkg;
  localparam int nbit = 32;
endpackage

module p4_adder_arbiter
  import p4_adder_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*nbit-1:0] req_a,
  input  logic [NREQ*nbit-1:0] req_b,
  input  logic [NREQ-1:0]      req_cin,
`ifdef P4_ARB_SUB_EN
  input  logic [NREQ-1:0]      req_sub,
`endif
  output logic [nbit-1:0]      add_a,
  output logic [nbit-1:0]      add_b,
  output logic                 add_cin,
  input  logic [nbit-1:0]      add_s,
  input  logic                 add_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [nbit-1:0]      rsp_s,
  output logic                 rsp_cout
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  idx_w;
  int              idx;
  logic            found;
  logic [nbit-1:0] sel_a, sel_b;
  logic            sel_cin;
  logic [nbit-1:0] op_a, op_b;
  logic            op_cin;
  logic            accept;
  logic            rsp_hs;
  logic [nbit-1:0] a_arr [NREQ];
  logic [nbit-1:0] b_arr [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign a_arr[k] = req_a[k*nbit +: nbit];
    assign b_arr[k] = req_b[k*nbit +: nbit];
  end

  // Upward search from ptr with wrap; first valid requester wins.
  always_comb begin
    found   = 1'b0;
    gnt     = '0;
    idx     = 0;
    idx_w   = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IDW'(idx);
      if (!found && req_valid[idx_w]) begin
        found   = 1'b1;
        gnt     = idx_w;
        sel_a   = a_arr[idx_w];
        sel_b   = b_arr[idx_w];
        sel_cin = req_cin[idx_w];
`ifdef P4_ARB_SUB_EN
        if (req_sub[idx_w]) begin
          sel_b   = ~b_arr[idx_w];
          sel_cin = 1'b1;
        end
`endif
      end
    end
  end

  assign accept    = (state == IDLE) && found;
  assign rsp_valid = (state == RESP);
  assign rsp_hs    = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      rsp_id   <= '0;
      rsp_s    <= '0;
      rsp_cout <= 1'b0;
    end else begin
      if (accept) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_cin <= sel_cin;
        rsp_id <= gnt;
      end
      if (state == ISSUE) begin
        rsp_s    <= add_s;
        rsp_cout <= add_cout;
      end
      if (rsp_hs) begin
        if (rsp_id == IDW'(NREQ-1)) ptr <= '0;
        else                        ptr <= rsp_id + IDW'(1);
      end
    end
  end

  // Operand registers feed the shared adder and only change on acceptance.
  assign add_a   = op_a;
  assign add_b   = op_b;
  assign add_cin = op_cin;

endmodule

// File: tb/tb_p4_adder_arbiter.sv
// Directed self-checking bench for p4_adder_arbiter; the bench also plays the shared combinational adder.
module tb_p4_adder_arbiter;
  localparam int NREQ = 4;
  localparam int NB   = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*NB-1:0] req_a, req_b;
  logic [NREQ-1:0] req_cin;
`ifdef P4_ARB_SUB_EN
  logic [NREQ-1:0] req_sub;
`endif
  logic [NB-1:0]   add_a, add_b, add_s;
  logic            add_cin, add_cout;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_id;
  logic [NB-1:0]   rsp_s;
  logic            rsp_cout;

  int checks = 0;
  int errors = 0;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{NB{1'b0}}, add_cin};

  always #5 clk = ~clk;

  p4_adder_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
`ifdef P4_ARB_SUB_EN
    .req_sub(req_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_cout(rsp_cout)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [NB-1:0] a, input logic [NB-1:0] b, input logic cin);
    req_a[id*NB +: NB] = a;
    req_b[id*NB +: NB] = b;
    req_cin[id]        = cin;
  endtask

  // One transaction from a single requester with rsp_ready held high.
  task automatic serve(input string tag, input int id, input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic cin, input logic [NB-1:0] es, input logic ec);
    logic [NREQ-1:0] onehot;
    onehot = '0;
    onehot[id] = 1'b1;
    set_req(id, a, b, cin);
    req_valid = onehot;
    #1;
    chk({tag, ".ready"}, req_ready, onehot);
    tick();
    req_valid = '0;
    chk({tag, ".issue_vld"}, rsp_valid, 0);
    tick();
    chk({tag, ".vld"}, rsp_valid, 1);
    chk({tag, ".id"}, rsp_id, id);
    chk({tag, ".s"}, rsp_s, es);
    chk({tag, ".cout"}, rsp_cout, ec);
    tick();
    chk({tag, ".idle_vld"}, rsp_valid, 0);
  endtask

  logic [NB-1:0] rot_s [NREQ];

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
`ifdef P4_ARB_SUB_EN
    req_sub = '0;
`endif
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst.ready", req_ready, 0);
    chk("rst.add_a", add_a, 0);
    chk("rst.add_b", add_b, 0);
    chk("rst.add_cin", add_cin, 0);
    chk("rst.vld", rsp_valid, 0);
    chk("rst.id", rsp_id, 0);
    chk("rst.s", rsp_s, 0);
    chk("rst.cout", rsp_cout, 0);
    rst = 1'b0;

    // req0 5+3+1; issue-cycle adder drive checked explicitly once.
    set_req(0, 32'h5, 32'h3, 1'b1);
    req_valid = 4'b0001;
    #1;
    chk("t1.ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("t1.add_a", add_a, 32'h5);
    chk("t1.add_b", add_b, 32'h3);
    chk("t1.add_cin", add_cin, 1);
    chk("t1.issue_vld", rsp_valid, 0);
    tick();
    chk("t1.vld", rsp_valid, 1);
    chk("t1.s", rsp_s, 32'h9);
    chk("t1.cout", rsp_cout, 0);
    chk("t1.id", rsp_id, 0);
    tick();
    chk("t1.idle_vld", rsp_valid, 0);

    serve("ovf", 1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b1);
    serve("msb", 2, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h1, 1'b1);
    serve("wrap", 0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);

    // Rotation from reset with everyone valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h1000 * i + 32'h7, 32'h20 * i, i[0]);
    rot_s[0] = 32'h7;
    rot_s[1] = 32'h1028;
    rot_s[2] = 32'h2047;
    rot_s[3] = 32'h3068;
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 12; n++) begin
      chk($sformatf("rot%0d.ready", n), req_ready, 64'(1) << (n % NREQ));
      tick();
      chk($sformatf("rot%0d.issue_rdy", n), req_ready, 0);
      tick();
      chk($sformatf("rot%0d.id", n), rsp_id, n % NREQ);
      chk($sformatf("rot%0d.s", n), rsp_s, rot_s[n % NREQ]);
      tick();
    end

    // Back-pressure: req2 chosen from ptr=0, held in RESP for 5 cycles.
    req_valid = 4'b0100;
    set_req(2, 32'd10, 32'd20, 1'b0);
    rsp_ready = 1'b0;
    #1;
    chk("bp.ready", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1111;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d.vld", c), rsp_valid, 1);
      chk($sformatf("bp%0d.s", c), rsp_s, 32'd30);
      chk($sformatf("bp%0d.id", c), rsp_id, 2);
      chk($sformatf("bp%0d.ready", c), req_ready, 0);
      if (c < 4) tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.hs_ready", req_ready, 0);
    tick();
    chk("bp.resume", req_ready, 4'b1000);
    req_valid = '0;
    tick();

    // Reset in ISSUE: req2 granted from ptr=3, then discarded.
    set_req(2, 32'h1, 32'h1, 1'b0);
    req_valid = 4'b0100;
    #1;
    chk("ri.ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ri%0d.vld", c), rsp_valid, 0);
      tick();
    end
    req_valid = 4'b1111;
    #1;
    chk("ri.ptr0", req_ready, 4'b0001);
    req_valid = '0;
    tick();

`ifdef P4_ARB_SUB_EN
    req_sub = 4'b0010;
    serve("sub_neg", 1, 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b0);
    serve("sub_pos", 1, 32'd5, 32'd3, 1'b0, 32'd2, 1'b1);
    req_sub = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/p4_adder_arbiter.md
# p4_adder_arbiter

Round-robin arbiter and sequencer sharing one combinational P4 adder (`p4_adder_if` datapath: `a`, `b`, `cin` in; `s`, `cout` out) among `NREQ` requesters. Each requester uses a valid/ready handshake. The block registers the winner's operands, drives the shared adder, captures the sum and carry, and returns them on a single response channel tagged with the requester index. It sits between the client logic and the single adder instance, so the adder is never driven by more than one requester.

## Interface
- `NREQ`, 4, number of requesters (2..16).
- `nbit`, from `p4_adder_pkg`, operand and sum width.
- `IDW`, `$clog2(NREQ)`, width of requester index.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero.
- `req_a`  in  NREQ×nbit  operand A per requester.
- `req_b`  in  NREQ×nbit  operand B per requester.
- `req_cin`  in  NREQ  carry-in per requester.
- `req_sub`  in  NREQ  subtract request; present only with `P4_ARB_SUB_EN`.
- `add_a`, `add_b`  out  nbit  to the shared adder's `a`/`b`.
- `add_cin`  out  1  to the shared adder's `cin`.
- `add_s`  in  nbit  from the shared adder's `s`.
- `add_cout`  in  1  from the shared adder's `cout`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester served.
- `rsp_s`  out  nbit  registered sum.
- `rsp_cout`  out  1  registered carry-out.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - Grant index `g` = first set `req_valid` bit searching upward from pointer `ptr`, wrapping at NREQ-1 → 0.
  - `req_ready[g]`=1 combinationally; all other bits are 0. `req_ready` is all zero when no request is valid.
  - On the handshake edge: latch `req_a[g]`, `req_b[g]`, `req_cin[g]` into operand registers, latch `g` into `rsp_id`, then go to ISSUE.
- **ISSUE**
  - Operand registers drive `add_a`/`add_b`/`add_cin`; these outputs are held unchanged in every state until the next acceptance.
  - At the end of the cycle, capture `add_s`→`rsp_s` and `add_cout`→`rsp_cout`, then go to RESP.
  - The adder is purely combinational and must settle within one `clk` period.
- **RESP**
  - `rsp_valid`=1; `rsp_s`, `rsp_cout` and `rsp_id` stay stable while `rsp_ready`=0.
  - On `rsp_valid & rsp_ready`: set `ptr` = (`rsp_id`+1) mod NREQ and return to IDLE.
- Requesters hold `req_valid` and their operands stable until accepted. `req_ready` is never asserted outside IDLE.
- Arithmetic: `rsp_s` = (A + B + cin) mod 2^nbit; `rsp_cout` = bit nbit of the full sum.
- Boundary behaviour:
  - All requesters valid: served in strict rotation, starting from index 0 after reset.
  - A requester that drops `req_valid` before grant loses nothing; it is simply skipped.
  - No request in IDLE: FSM stays in IDLE and all outputs hold.
  - `rst` asserted in any state: the in-flight transaction is discarded and no response is produced.
- Reset values: state=IDLE, `ptr`=0, `req_ready`=0, `add_a`=0, `add_b`=0, `add_cin`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_s`=0, `rsp_cout`=0.

## Timing
- Acceptance at rising edge k: ISSUE in cycle k..k+1, result captured at edge k+1, `rsp_valid`=1 from edge k+1.
- Latency: 2 cycles from request acceptance to response valid.
- Minimum spacing between acceptances: 3 cycles (IDLE, ISSUE, RESP with `rsp_ready`=1 throughout).
- Back-pressure: each cycle of `rsp_ready`=0 in RESP adds one cycle. No request is accepted during that time.
- `req_ready` depends combinationally on `req_valid`, `ptr` and state only. It never depends on `rsp_ready`.

## Configuration
- `P4_ARB_SUB_EN` defined:
  - `req_sub` port exists and is latched with the other operands.
  - When set: `add_b` = ~B, `add_cin` = 1 (requester's `req_cin` ignored). `rsp_s` = A − B mod 2^nbit; `rsp_cout`=1 means no borrow (A ≥ B unsigned).
- `P4_ARB_SUB_EN` not defined:
  - No `req_sub` port; addition only, exactly as described in Operation.

## Test plan
- Reset, then a single request on req0 with A=0x0000_0005, B=0x0000_0003, cin=1 → `req_ready[0]` high in the same cycle; `rsp_valid` 2 cycles later with `rsp_s`=0x9, `rsp_cout`=0, `rsp_id`=0.
- Overflow: A=0xFFFF_FFFF, B=0x0000_0001, cin=0 (nbit=32) → `rsp_s`=0x0, `rsp_cout`=1.
- All 4 requesters held valid for 12 transactions → grant order 0,1,2,3,0,1,2,3,…; each `rsp_id` matches; one acceptance every 3 cycles.
- `rsp_ready` held low for 5 cycles in RESP → `rsp_*` stable, `req_ready`=0 throughout; acceptance resumes 1 cycle after the response handshake.
- `rst` pulsed in ISSUE → `rsp_valid` never asserts for that transaction; next grant comes from `ptr`=0.
- With `P4_ARB_SUB_EN`: `req_sub`=1, A=3, B=5 → `rsp_s`=0xFFFF_FFFE, `rsp_cout`=0. Then A=5, B=3 → `rsp_s`=2, `rsp_cout`=1.
